capacity_seq: RTL and testbench

//  Multi-cycle sequencer computing channel capacity C = W*log2(1+S/N) in fixed point.

---
 rtl/capacity_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_capacity_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/capacity_seq.sv
// capacity_seq: multi-cycle sequencer computing C = W * log2(1 + S/N) in fixed point.
// One operation at a time: restoring divide, MSB-first log2 by repeated squaring,
// then a shift-add multiply. Results are Q(WW+LI).FRAC, log2 floor-truncated.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both high. The producer holds its data stable while valid
// is high and ready is low. in_ready is high only in IDLE. out_valid is high only
// in DONE, and c_out/err_out stay stable for as long as out_valid is high.
module capacity_seq #(
  parameter int WW   = 16,
  parameter int PW   = 16,
  parameter int FRAC = 8,
  localparam int LI  = $clog2(PW + 1),
  localparam int CW  = WW + LI + FRAC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WW-1:0] w_in,
  input  logic [PW-1:0] s_in,
  input  logic [PW-1:0] n_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] c_out,
  output logic          err_out
);

  // FSM encoding
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DIV  = 3'd1;
  localparam logic [2:0] S_LOGI = 3'd2;
  localparam logic [2:0] S_LOGF = 3'd3;
  localparam logic [2:0] S_MUL  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // one down-counter serves every multi-cycle phase
  localparam int MAXC = (PW > FRAC) ? ((PW > WW) ? PW : WW) : ((FRAC > WW) ? FRAC : WW);
  localparam int CNW  = $clog2(MAXC + 1);

  logic [2:0]      state_q, state_d;
  logic [CNW-1:0]  cnt_q, cnt_d;
  logic [WW-1:0]   w_q, w_d;       // bandwidth, shifted out MSB-first during MUL
  logic [PW-1:0]   d_q, d_d;       // dividend S, becomes quotient during DIV
  logic [PW-1:0]   n_q, n_d;       // divisor N
  logic [PW-1:0]   rem_q, rem_d;   // division partial remainder (always < N)
  logic [LI-1:0]   l_q, l_d;       // integer part of log2
  logic [PW:0]     m_q, m_d;       // mantissa Q1.PW, held in [1,2) between steps
  logic [FRAC-1:0] frac_q, frac_d; // fractional log2 bits, MSB first
  logic [CW-1:0]   acc_q, acc_d;   // product accumulator
  logic [CW-1:0]   c_q, c_d;       // registered result
  logic            err_q, err_d;   // registered divide-by-zero flag

  // datapath temporaries
  logic [PW:0]       trial;
  logic              qbit;
  logic [PW:0]       x;
  logic [LI-1:0]     lsel;
  logic [LI-1:0]     shamt;
  logic [PW:0]       xs;
  logic [2*PW+1:0]   sq;
  logic [PW+1:0]     sq_t;
  logic              fbit;
  logic [CW-1:0]     acc_nx;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign c_out     = c_q;
  assign err_out   = err_q;

  // next-state and datapath for every phase of the sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    d_d     = d_q;
    n_d     = n_q;
    rem_d   = rem_q;
    l_d     = l_q;
    m_d     = m_q;
    frac_d  = frac_q;
    acc_d   = acc_q;
    c_d     = c_q;
    err_d   = err_q;
    trial   = '0;
    qbit    = 1'b0;
    x       = '0;
    lsel    = '0;
    shamt   = '0;
    xs      = '0;
    sq      = '0;
    sq_t    = '0;
    fbit    = 1'b0;
    acc_nx  = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          w_d    = w_in;
          d_d    = s_in;
          n_d    = n_in;
          rem_d  = '0;
          acc_d  = '0;
          frac_d = '0;
          l_d    = '0;
          m_d    = '0;
          if (n_in == '0) begin
            // no useful capacity without a noise floor: flag and report zero
            state_d = S_DONE;
            c_d     = '0;
            err_d   = 1'b1;
          end else begin
            state_d = S_DIV;
            cnt_d   = CNW'(PW - 1);
          end
        end
      end

      S_DIV: begin
        // restoring step: bring down next dividend bit, subtract if it fits
        trial = {rem_q, d_q[PW-1]};
        if (trial >= {1'b0, n_q}) begin
          rem_d = PW'(trial - {1'b0, n_q});
          qbit  = 1'b1;
        end else begin
          rem_d = trial[PW-1:0];
        end
        d_d = {d_q[PW-2:0], qbit};
        if (cnt_q == '0) begin
          state_d = S_LOGI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_LOGI: begin
        // x = q+1 is never zero; its MSB index is the integer log2
        x = {1'b0, d_q} + 1'b1;
        for (int i = 0; i <= PW; i++) begin
          if (x[i]) lsel = LI'(i);
        end
        shamt   = LI'(PW) - lsel;
        xs      = x << shamt;
        m_d     = xs;
        l_d     = lsel;
        cnt_d   = CNW'(FRAC - 1);
        state_d = S_LOGF;
      end

      S_LOGF: begin
        // square the mantissa; crossing 2.0 yields a 1 bit and renormalises
        sq   = {{(PW+1){1'b0}}, m_q} * {{(PW+1){1'b0}}, m_q};
        sq_t = (PW+2)'(sq >> PW);
        if (sq_t[PW+1]) begin
          fbit = 1'b1;
          m_d  = sq_t[PW+1:1];
        end else begin
          m_d  = sq_t[PW:0];
        end
        frac_d = {frac_q[FRAC-2:0], fbit};
        if (cnt_q == '0) begin
          state_d = S_MUL;
          cnt_d   = CNW'(WW - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_MUL: begin
        // MSB-first shift-add of W times {L, frac}
        acc_nx = (acc_q << 1) + (w_q[WW-1] ? CW'({l_q, frac_q}) : '0);
        acc_d  = acc_nx;
        w_d    = w_q << 1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          c_d     = acc_nx;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      d_q     <= '0;
      n_q     <= '0;
      rem_q   <= '0;
      l_q     <= '0;
      m_q     <= '0;
      frac_q  <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      d_q     <= d_d;
      n_q     <= n_d;
      rem_q   <= rem_d;
      l_q     <= l_d;
      m_q     <= m_d;
      frac_q  <= frac_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_capacity_seq.sv
// Testbench for capacity_seq: directed vectors plus randomized operations
// checked against an arithmetic model of C = W * log2(1 + S/N).
module tb_capacity_seq;

  localparam int WW   = 16;
  localparam int PW   = 16;
  localparam int FRAC = 8;
  localparam int LI   = $clog2(PW + 1);
  localparam int CW   = WW + LI + FRAC;
  localparam int LAT  = PW + FRAC + WW + 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] w_in;
  logic [PW-1:0] s_in;
  logic [PW-1:0] n_in;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] c_out;
  logic          err_out;

  int checks   = 0;
  int failures = 0;

  logic [CW:0] exp_q[$];

  capacity_seq #(.WW(WW), .PW(PW), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .w_in      (w_in),
    .s_in      (s_in),
    .n_in      (n_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_out     (c_out),
    .err_out   (err_out)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: floor(S/N), integer log2 as largest power of two <= x,
  // fraction bits from successive squaring truncated to PW fractional bits
  function automatic longint model_c(input longint w, input longint s, input longint n);
    longint q, x, l, m, fr;
    if (n == 0) return 0;
    q = s / n;
    x = q + 1;
    l = 0;
    while ((longint'(2) << l) <= x) l++;
    m = x << (PW - l);
    fr = 0;
    for (int i = 0; i < FRAC; i++) begin
      m  = (m * m) >> PW;
      fr = fr * 2;
      if (m >= (longint'(2) << PW)) begin
        fr = fr + 1;
        m  = m >> 1;
      end
    end
    return w * (l * (longint'(1) << FRAC) + fr);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one full operation: handshake, latency, result, optional back-pressure, release
  task automatic do_op(input logic [WW-1:0] w, input logic [PW-1:0] s, input logic [PW-1:0] n,
                       input logic [CW-1:0] ec, input logic ee, input int hold);
    int lat;
    int waitc;
    logic [CW:0] e;
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      tick();
      waitc++;
    end
    check("in_ready_before_op", in_ready, 1'b1);
    exp_q.push_back({ee, ec});
    in_valid = 1'b1;
    w_in = w;
    s_in = s;
    n_in = n;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    e = exp_q.pop_front();
    check("latency", 64'(lat), (n == '0) ? 64'd1 : 64'(LAT));
    check("c_out", c_out, e[CW-1:0]);
    check("err_out", err_out, e[CW]);
    check("in_ready_busy", in_ready, 1'b0);
    if (hold > 0) begin
      // junk operands offered while the result is stalled must be ignored
      in_valid = 1'b1;
      w_in = WW'($urandom);
      s_in = PW'($urandom);
      n_in = PW'($urandom);
      repeat (hold) tick();
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_c_out", c_out, e[CW-1:0]);
      check("hold_err_out", err_out, e[CW]);
      check("hold_in_ready", in_ready, 1'b0);
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 1'b0);
    check("release_in_ready", in_ready, 1'b1);
    check("idle_c_out_held", c_out, e[CW-1:0]);
  endtask

  // directed steps then randomized operations
  initial begin
    logic [WW-1:0] rw;
    logic [PW-1:0] rs;
    logic [PW-1:0] rn;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    w_in = '0;
    s_in = '0;
    n_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_c_out", c_out, '0);
    check("reset_err_out", err_out, 1'b0);

    do_op(16'd1000, 16'd3, 16'd1, CW'(512000), 1'b0, 0);
    do_op(16'd1, 16'd2, 16'd1, CW'(405), 1'b0, 0);
    do_op(16'd500, 16'd0, 16'd9, CW'(0), 1'b0, 0);
    do_op(16'd7, 16'd5, 16'd0, CW'(0), 1'b1, 0);
    do_op(16'hFFFF, 16'hFFFF, 16'd1, CW'(32'hFFFF000), 1'b0, 0);
    do_op(16'd0, 16'd100, 16'd3, CW'(0), 1'b0, 0);
    do_op(16'd1000, 16'd3, 16'd1, CW'(512000), 1'b0, 20);

    // reset in the middle of the multiply phase
    do_op(16'd300, 16'd7, 16'd2, CW'(model_c(300, 7, 2)), 1'b0, 0);
    in_valid = 1'b1;
    w_in = 16'd1000;
    s_in = 16'd3;
    n_in = 16'd1;
    tick();
    in_valid = 1'b0;
    repeat (29) tick();
    check("pre_rst_out_valid", out_valid, 1'b0);
    check("pre_rst_c_out", c_out, CW'(model_c(300, 7, 2)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_c_out", c_out, '0);
    check("rst_mid_in_ready", in_ready, 1'b1);
    do_op(16'd1, 16'd2, 16'd1, CW'(405), 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      rw = WW'($urandom_range(0, 65535));
      rs = PW'($urandom_range(0, 65535));
      if ($urandom_range(0, 2) == 0) rn = PW'($urandom_range(1, 15));
      else if ($urandom_range(0, 9) == 0) rn = '0;
      else rn = PW'($urandom_range(1, 65535));
      do_op(rw, rs, rn, CW'(model_c(longint'(rw), longint'(rs), longint'(rn))),
            (rn == '0), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
